// File: rtl/fila_pkg.sv
// Shared types and defaults for the fila_param queue.
package fila_pkg;

    typedef enum logic [1:0] {
        AGUARDA = 2'd0,
        GRAVA   = 2'd1,
        LE      = 2'd2,
        ESPERA  = 2'd3
    } state_t;

    localparam int unsigned FILA_DATA_W = 8;
    localparam int unsigned FILA_DEPTH  = 8;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int unsigned fila_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fila_param.sv
// Parametrised FIFO driven by level-held requests: one operation per press,
// with full/empty status, sticky overflow/underflow and optional head peek.
module fila_param
    import fila_pkg::*;
#(
    parameter int unsigned DATA_W = FILA_DATA_W,
    parameter int unsigned DEPTH  = FILA_DEPTH,
    parameter int unsigned PEEK   = 0
) (
    input  logic              clock_10KHz,
    input  logic              reset,
    input  logic              enqueue_in,
    input  logic              dequeue_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [7:0]        len_out,
    output logic [DATA_W-1:0] data_out,
    output logic              full_out,
    output logic              empty_out,
    output logic              ovf_out,
    output logic              udf_out,
    output logic              busy_out
);

    localparam int unsigned PTR_W = fila_ptr_w(DEPTH);

    logic [DATA_W-1:0] fila [DEPTH];

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [7:0]        len_q, len_d;
    logic [DATA_W-1:0] data_reg_q, data_reg_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              busy_q, busy_d;
    logic              wr_en;

    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            state_q    <= AGUARDA;
            head_q     <= '0;
            tail_q     <= '0;
            len_q      <= '0;
            data_reg_q <= '0;
            data_out_q <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            len_q      <= len_d;
            data_reg_q <= data_reg_d;
            data_out_q <= data_out_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            busy_q     <= busy_d;
        end
    end

    // Storage is deliberately not reset; reset only makes old entries unreachable.
    always_ff @(posedge clock_10KHz) begin
        if (wr_en) begin
            fila[tail_q] <= data_reg_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        len_d      = len_q;
        data_reg_d = data_reg_q;
        data_out_d = data_out_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        wr_en      = 1'b0;

        // Peek mode follows the head whenever there is one; a pop below overrides.
        if (PEEK != 0 && len_q != 8'd0) begin
            data_out_d = fila[head_q];
        end

        case (state_q)
            AGUARDA: begin
                if (enqueue_in && !dequeue_in) begin
                    state_d    = GRAVA;
                    data_reg_d = data_in;
                end else if (dequeue_in && !enqueue_in) begin
                    state_d = LE;
                end else if (enqueue_in && dequeue_in) begin
                    state_d = ESPERA;
                end
            end
            GRAVA: begin
                if (len_q != 8'(DEPTH)) begin
                    wr_en  = 1'b1;
                    tail_d = tail_q + PTR_W'(1);
                    len_d  = len_q + 8'd1;
                end else begin
                    ovf_d = 1'b1;
                end
                state_d = ESPERA;
            end
            LE: begin
                if (len_q != 8'd0) begin
                    data_out_d = fila[head_q];
                    head_d     = head_q + PTR_W'(1);
                    len_d      = len_q - 8'd1;
                end else begin
                    udf_d = 1'b1;
                end
                state_d = ESPERA;
            end
            ESPERA: begin
                if (!enqueue_in && !dequeue_in) begin
                    state_d = AGUARDA;
                end
            end
            default: state_d = AGUARDA;
        endcase

        full_d  = (len_d == 8'(DEPTH));
        empty_d = (len_d == 8'd0);
        busy_d  = (state_d != AGUARDA);
    end

    assign len_out   = len_q;
    assign data_out  = data_out_q;
    assign full_out  = full_q;
    assign empty_out = empty_q;
    assign ovf_out   = ovf_q;
    assign udf_out   = udf_q;
    assign busy_out  = busy_q;

endmodule

// File: tb/tb_fila_param.sv
// Self-checking bench for fila_param: queue-based reference model plus directed checks.
`timescale 1ns/1ps
module tb_fila_param;

    logic       clk;
    logic       reset;
    logic       enq;
    logic       deq;
    logic [7:0] din;

    logic [7:0] len0, dout0, len1, dout1;
    logic       full0, empty0, ovf0, udf0, busy0;
    logic       full1, empty1, ovf1, udf1, busy1;

    int checks   = 0;
    int failures = 0;

    fila_param #(.DATA_W(8), .DEPTH(8), .PEEK(0)) dut (
        .clock_10KHz(clk), .reset(reset), .enqueue_in(enq), .dequeue_in(deq),
        .data_in(din), .len_out(len0), .data_out(dout0), .full_out(full0),
        .empty_out(empty0), .ovf_out(ovf0), .udf_out(udf0), .busy_out(busy0)
    );

    fila_param #(.DATA_W(8), .DEPTH(8), .PEEK(1)) dut_p (
        .clock_10KHz(clk), .reset(reset), .enqueue_in(enq), .dequeue_in(deq),
        .data_in(din), .len_out(len1), .data_out(dout1), .full_out(full1),
        .empty_out(empty1), .ovf_out(ovf1), .udf_out(udf1), .busy_out(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a queue plus "one operation per press" bookkeeping.
    logic [7:0] m_q[$];
    int         m_pending;   // 0 none, 1 push due next edge, 2 pop due next edge
    bit         m_locked;    // a press has been consumed, waiting for release
    logic [7:0] m_latch;
    logic [7:0] m_dout;
    bit         m_ovf, m_udf;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_pending = 0;
            m_locked  = 0;
            m_latch   = 8'h00;
            m_dout    = 8'h00;
            m_ovf     = 0;
            m_udf     = 0;
        end else if (m_pending == 1) begin
            if (m_q.size() < 8) m_q.push_back(m_latch);
            else m_ovf = 1;
            m_pending = 0;
        end else if (m_pending == 2) begin
            if (m_q.size() > 0) m_dout = m_q.pop_front();
            else m_udf = 1;
            m_pending = 0;
        end else if (m_locked) begin
            if (!enq && !deq) m_locked = 0;
        end else if (enq && !deq) begin
            m_pending = 1;
            m_latch   = din;
            m_locked  = 1;
        end else if (deq && !enq) begin
            m_pending = 2;
            m_locked  = 1;
        end else if (enq && deq) begin
            m_locked = 1;
        end
        #1;
        chk("m_len",   32'(len0),   32'(m_q.size()));
        chk("m_dout",  32'(dout0),  32'(m_dout));
        chk("m_full",  32'(full0),  32'(m_q.size() == 8));
        chk("m_empty", 32'(empty0), 32'(m_q.size() == 0));
        chk("m_ovf",   32'(ovf0),   32'(m_ovf));
        chk("m_udf",   32'(udf0),   32'(m_udf));
        chk("m_busy",  32'(busy0),  32'(m_locked || m_pending != 0));
    end

    task automatic op(input bit e, input bit d, input logic [7:0] v, input int hold);
        @(negedge clk);
        enq = e; deq = d; din = v;
        repeat (hold) @(negedge clk);
        enq = 1'b0; deq = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_v;
        reset = 1'b1; enq = 1'b0; deq = 1'b0; din = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_len",   32'(len0),   32'h0);
        chk("rst_empty", 32'(empty0), 32'h1);
        chk("rst_busy",  32'(busy0),  32'h0);
        reset = 1'b0;

        // Basic ordering
        op(1, 0, 8'h11, 3); op(1, 0, 8'h22, 3); op(1, 0, 8'h33, 3);
        chk("three_len",   32'(len0),   32'h3);
        chk("three_empty", 32'(empty0), 32'h0);
        op(0, 1, 8'h00, 3); chk("pop1", 32'(dout0), 32'h11);
        op(0, 1, 8'h00, 3); chk("pop2", 32'(dout0), 32'h22);
        op(0, 1, 8'h00, 3); chk("pop3", 32'(dout0), 32'h33);
        chk("drain_len",   32'(len0),   32'h0);
        chk("drain_empty", 32'(empty0), 32'h1);

        // Long hold writes exactly once
        @(negedge clk);
        enq = 1'b1; din = 8'hA5;
        repeat (20) @(negedge clk);
        chk("hold_len", 32'(len0), 32'h1);
        enq = 1'b0;
        chk("hold_busy_before", 32'(busy0), 32'h1);
        @(negedge clk);
        chk("hold_busy_after", 32'(busy0), 32'h0);
        op(0, 1, 8'h00, 3);
        chk("hold_pop", 32'(dout0), 32'hA5);

        // Fill, overflow, drain
        for (int i = 1; i <= 8; i++) op(1, 0, 8'(i), 3);
        op(1, 0, 8'hFF, 3);
        chk("ovf_len",  32'(len0),  32'h8);
        chk("ovf_full", 32'(full0), 32'h1);
        chk("ovf_flag", 32'(ovf0),  32'h1);
        for (int i = 1; i <= 8; i++) begin
            op(0, 1, 8'h00, 3);
            chk("fill_pop", 32'(dout0), 32'(i));
        end

        // Pointer wrap with occupancy capped at three
        exp_v = 8'h01;
        for (int i = 1; i <= 12; i++) begin
            op(1, 0, 8'(i), 3);
            if (len0 == 8'd3) begin
                op(0, 1, 8'h00, 3);
                chk("wrap_pop", 32'(dout0), 32'(exp_v));
                exp_v = exp_v + 8'd1;
            end
        end
        while (exp_v <= 8'h0C) begin
            op(0, 1, 8'h00, 3);
            chk("wrap_tail", 32'(dout0), 32'(exp_v));
            exp_v = exp_v + 8'd1;
        end

        // Underflow right after reset, then simultaneous requests
        do_reset();
        chk("rst_ovf", 32'(ovf0), 32'h0);
        op(0, 1, 8'h00, 3);
        chk("udf_flag", 32'(udf0),  32'h1);
        chk("udf_dout", 32'(dout0), 32'h0);
        chk("udf_len",  32'(len0),  32'h0);
        op(1, 1, 8'h77, 3);
        chk("both_len", 32'(len0), 32'h0);
        chk("both_ovf", 32'(ovf0), 32'h0);

        // Peek mode shows the head without a pop
        op(1, 0, 8'h5A, 3);
        chk("peek_head",   32'(dout1), 32'h5A);
        chk("nopeek_dout", 32'(dout0), 32'h00);
        op(1, 0, 8'h3C, 3);
        op(0, 1, 8'h00, 3);
        chk("peek_after_pop",   32'(dout1), 32'h3C);
        chk("nopeek_after_pop", 32'(dout0), 32'h5A);

        // Reset landing while a write is in flight
        @(negedge clk);
        enq = 1'b1; din = 8'h99;
        @(negedge clk);
        chk("grava_busy", 32'(busy0), 32'h1);
        reset = 1'b1;
        #1;
        chk("arst_len",   32'(len0),   32'h0);
        chk("arst_busy",  32'(busy0),  32'h0);
        chk("arst_empty", 32'(empty0), 32'h1);
        chk("arst_dout",  32'(dout0),  32'h0);
        chk("arst_pdout", 32'(dout1),  32'h0);
        chk("arst_udf",   32'(udf0),   32'h0);
        enq = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_len", 32'(len1), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
